// File: rtl/logic16_chk_pkg.sv
// logic16_chk_pkg: op encodings and FSM state type for the logic16 result checker
package logic16_chk_pkg;
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/logic16_ref_unit.sv
// logic16_ref_unit: combinational reference model producing the expected logic result
module logic16_ref_unit
    import logic16_chk_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] exp_y
);
    always_comb begin
        exp_y = (op == OP_AND) ? (a & b) :
                (op == OP_OR)  ? (a | b) :
                (op == OP_XOR) ? (a ^ b) : ~(a & b);
    end
endmodule

// File: rtl/logic16_result_checker.sv
// logic16_result_checker: compares streamed DUT results against a reference and tallies errors
module logic16_result_checker
    import logic16_chk_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] fail_idx,
    output logic [WIDTH-1:0] fail_y,
    output logic [WIDTH-1:0] fail_exp
);
    state_t           state, next_state;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] vec_next;
    logic [WIDTH-1:0] exp_y;
    logic             failed;
    logic             accept;
    logic             mismatch;
    logic             last;

    logic16_ref_unit #(.WIDTH(WIDTH)) u_ref (
        .a     (a),
        .b     (b),
        .op    (op_q),
        .exp_y (exp_y)
    );

    // start wins over a same-cycle sample, which is dropped
    assign accept   = in_valid && (state == RUN) && !start;
    assign mismatch = (y != exp_y);
    assign vec_next = vec_count + CNT_W'(1);
    assign last     = (vec_next == num_q);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = start ? ((num_vec == '0) ? DONE : RUN) :
                     (accept && last) ? DONE : state;
    end

    always_comb begin
        busy     = (state == RUN);
        in_ready = (state == RUN);
        done     = (state == DONE);
        pass     = (state == DONE) && (err_count == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= '0;
            num_q     <= '0;
            vec_count <= '0;
            err_count <= '0;
            fail_idx  <= '0;
            fail_y    <= '0;
            fail_exp  <= '0;
            failed    <= 1'b0;
        end else if (start) begin
            op_q      <= op;
            num_q     <= num_vec;
            vec_count <= '0;
            err_count <= '0;
            fail_idx  <= '0;
            fail_y    <= '0;
            fail_exp  <= '0;
            failed    <= 1'b0;
        end else if (accept) begin
            vec_count <= vec_next;
            if (mismatch) begin
                err_count <= (err_count == '1) ? err_count : err_count + CNT_W'(1);
                if (!failed) begin
                    failed   <= 1'b1;
                    fail_idx <= vec_count;
                    fail_y   <= y;
                    fail_exp <= exp_y;
                end
            end
        end
    end
endmodule

// File: tb/tb_logic16_result_checker.sv
// tb_logic16_result_checker: table-driven directed bench plus reset/restart sequences
module tb_logic16_result_checker;
    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, in_ready, busy, done, pass;
    logic [1:0]  op;
    logic [15:0] num_vec, a, b, y, vec_count, err_count, fail_idx, fail_y, fail_exp;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic        st;
        logic [1:0]  op;
        logic [15:0] nv;
        logic        v;
        logic [15:0] a, b, y;
        logic        busy, done, pass;
        logic [15:0] vc, ec;
    } rec_t;

    rec_t tbl[$];

    logic16_result_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .num_vec(num_vec),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .y(y),
        .busy(busy), .done(done), .pass(pass), .vec_count(vec_count),
        .err_count(err_count), .fail_idx(fail_idx), .fail_y(fail_y), .fail_exp(fail_exp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [1:0] o, input logic [15:0] nv,
                         input logic v, input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] vy);
        start = st; op = o; num_vec = nv; in_valid = v; a = va; b = vb; y = vy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic bz, input logic dn, input logic ps,
                             input logic [15:0] vc, input logic [15:0] ec);
        chk({tag, " busy"}, busy, bz);
        chk({tag, " in_ready"}, in_ready, bz);
        chk({tag, " done"}, done, dn);
        chk({tag, " pass"}, pass, ps);
        chk({tag, " vec_count"}, vec_count, vc);
        chk({tag, " err_count"}, err_count, ec);
    endtask

    task automatic chk_fail(input string tag, input logic [15:0] idx, input logic [15:0] fy,
                            input logic [15:0] fe);
        chk({tag, " fail_idx"}, fail_idx, idx);
        chk({tag, " fail_y"}, fail_y, fy);
        chk({tag, " fail_exp"}, fail_exp, fe);
    endtask

    initial begin
        // AND run, all correct
        tbl.push_back('{1, 2'd0, 16'd4, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 16'd0, 16'd0});
        tbl.push_back('{0, 2'd0, 16'd0, 1, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 16'd1, 16'd0});
        tbl.push_back('{0, 2'd0, 16'd0, 1, 16'hFFFF, 16'h0000, 16'h0000, 1, 0, 0, 16'd2, 16'd0});
        tbl.push_back('{0, 2'd0, 16'd0, 1, 16'hCCCC, 16'hAAAA, 16'h8888, 1, 0, 0, 16'd3, 16'd0});
        tbl.push_back('{0, 2'd0, 16'd0, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 1, 1, 16'd4, 16'd0});
        tbl.push_back('{0, 2'd0, 16'd0, 1, 16'h1111, 16'h2222, 16'h1234, 0, 1, 1, 16'd4, 16'd0});
        // AND run with one mismatch at index 1
        tbl.push_back('{1, 2'd0, 16'd3, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 16'd0, 16'd0});
        tbl.push_back('{0, 2'd0, 16'd0, 1, 16'h0001, 16'h0001, 16'h0001, 1, 0, 0, 16'd1, 16'd0});
        tbl.push_back('{0, 2'd0, 16'd0, 1, 16'h3CAF, 16'hC3AC, 16'h00AD, 1, 0, 0, 16'd2, 16'd1});
        tbl.push_back('{0, 2'd0, 16'd0, 1, 16'h0F0F, 16'h00FF, 16'h000F, 0, 1, 0, 16'd3, 16'd1});
        // XOR run with in_valid toggling
        tbl.push_back('{1, 2'd2, 16'd2, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 16'd0, 16'd0});
        tbl.push_back('{0, 2'd0, 16'd0, 1, 16'hF0F0, 16'h0FF0, 16'hFF00, 1, 0, 0, 16'd1, 16'd0});
        tbl.push_back('{0, 2'd0, 16'd0, 0, 16'hDEAD, 16'hBEEF, 16'h0000, 1, 0, 0, 16'd1, 16'd0});
        tbl.push_back('{0, 2'd0, 16'd0, 1, 16'h1234, 16'h1234, 16'h0000, 0, 1, 1, 16'd2, 16'd0});
        tbl.push_back('{0, 2'd0, 16'd0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1, 16'd2, 16'd0});
        tbl.push_back('{0, 2'd0, 16'd0, 1, 16'h5555, 16'h0000, 16'hAAAA, 0, 1, 1, 16'd2, 16'd0});
        // num_vec == 0
        tbl.push_back('{1, 2'd0, 16'd0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1, 16'd0, 16'd0});
        // OR run, second result wrong
        tbl.push_back('{1, 2'd1, 16'd2, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 16'd0, 16'd0});
        tbl.push_back('{0, 2'd0, 16'd0, 1, 16'h00F0, 16'h0F00, 16'h0FF0, 1, 0, 0, 16'd1, 16'd0});
        tbl.push_back('{0, 2'd0, 16'd0, 1, 16'h1200, 16'h0034, 16'h1230, 0, 1, 0, 16'd2, 16'd1});
        // NAND run
        tbl.push_back('{1, 2'd3, 16'd1, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 16'd0, 16'd0});
        tbl.push_back('{0, 2'd0, 16'd0, 1, 16'hFF00, 16'h0F0F, 16'hF0FF, 0, 1, 1, 16'd1, 16'd0});

        rst_n = 1'b0;
        start = 0; op = 0; num_vec = 0; in_valid = 0; a = 0; b = 0; y = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 0, 0, 0, 16'd0, 16'd0);
        chk_fail("reset", 16'd0, 16'd0, 16'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].op, tbl[i].nv, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].y);
            chk_state($sformatf("vec%0d", i), tbl[i].busy, tbl[i].done, tbl[i].pass,
                      tbl[i].vc, tbl[i].ec);
            if (i == 9) chk_fail("and_err", 16'd1, 16'h00AD, 16'h00AC);
            if (i == 19) chk_fail("or_err", 16'd1, 16'h1230, 16'h1234);
        end

        // reset mid-run after two accepts, one of them a mismatch
        drive(1, 2'd0, 16'd5, 0, 0, 0, 0);
        drive(0, 2'd0, 16'd0, 1, 16'h00FF, 16'h0FF0, 16'h0000);
        drive(0, 2'd0, 16'd0, 1, 16'hFFFF, 16'h000F, 16'h000F);
        chk_state("pre_rst", 1, 0, 0, 16'd2, 16'd1);
        chk_fail("pre_rst", 16'd0, 16'h0000, 16'h00F0);
        rst_n = 1'b0;
        drive(1, 2'd1, 16'd3, 1, 16'h0001, 16'h0001, 16'h0000);
        chk_state("mid_rst", 0, 0, 0, 16'd0, 16'd0);
        chk_fail("mid_rst", 16'd0, 16'd0, 16'd0);
        rst_n = 1'b1;
        drive(0, 2'd0, 16'd0, 1, 16'h0001, 16'h0001, 16'h0000);
        chk_state("idle_ignore", 0, 0, 0, 16'd0, 16'd0);
        drive(1, 2'd0, 16'd1, 0, 0, 0, 0);
        drive(0, 2'd0, 16'd0, 1, 16'hA5A5, 16'hFF00, 16'hA500);
        chk_state("post_rst", 0, 1, 1, 16'd1, 16'd0);

        // restart over a failing run with a sample pending
        drive(1, 2'd2, 16'd3, 0, 0, 0, 0);
        drive(0, 2'd0, 16'd0, 1, 16'h000F, 16'h00F0, 16'h0000);
        chk_state("pre_restart", 1, 0, 0, 16'd1, 16'd1);
        chk_fail("pre_restart", 16'd0, 16'h0000, 16'h00FF);
        drive(1, 2'd0, 16'd2, 1, 16'h0000, 16'h0000, 16'hFFFF);
        chk_state("restart", 1, 0, 0, 16'd0, 16'd0);
        chk_fail("restart", 16'd0, 16'd0, 16'd0);
        drive(0, 2'd0, 16'd0, 1, 16'h00FF, 16'h0F0F, 16'h000F);
        drive(0, 2'd0, 16'd0, 1, 16'hFFFF, 16'h1234, 16'h1234);
        chk_state("restart_done", 0, 1, 1, 16'd2, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
